// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline stage register with a valid/ready handshake,
// a 2-entry skid buffer (OUT + SKID) and a flush input for branch/exception
// kill. ex_ready comes straight from the state flop, so MEM back-pressure
// never forms a combinational path into EX.
//
// Optional feature: define EX_MEM_FWD_EN to add the fwd_mem_* forwarding
// outputs (ALU-result bypass from the entry currently held in OUT).
module ex_mem_pipe #(
  parameter int XLEN    = 32,
  parameter int WMASK_W = 8,
  parameter int WBSEL_W = 2,
  parameter int RD_W    = 5
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               flush,

  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic               ex_is_write_dmem,
  input  logic [WBSEL_W-1:0] ex_wb_select,
  input  logic [WMASK_W-1:0] ex_write_width,
  input  logic [XLEN-1:0]    ex_dmem_write_data,
  input  logic [XLEN-1:0]    ex_alu_result,
  input  logic [RD_W-1:0]    ex_rd,
  input  logic               ex_rd_we,
  input  logic [XLEN-1:0]    ex_pc,

  output logic               mem_valid,
  input  logic               mem_ready,
  output logic               mem_is_write_dmem,
  output logic [WBSEL_W-1:0] mem_wb_select,
  output logic [WMASK_W-1:0] mem_write_width,
  output logic [XLEN-1:0]    mem_dmem_write_data,
  output logic [XLEN-1:0]    mem_alu_result,
  output logic [RD_W-1:0]    mem_rd,
  output logic               mem_rd_we,
  output logic [XLEN-1:0]    mem_pc
`ifdef EX_MEM_FWD_EN
  ,
  output logic               fwd_mem_valid,
  output logic [RD_W-1:0]    fwd_mem_rd,
  output logic [XLEN-1:0]    fwd_mem_data
`endif
);

  // Occupancy of the OUT/SKID pair. SKID is only ever valid when OUT is.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // wb_select code meaning "write back the ALU result".
  localparam logic [WBSEL_W-1:0] WBSEL_ALU = '0;

  typedef struct packed {
    logic               is_write_dmem;
    logic [WBSEL_W-1:0] wb_select;
    logic [WMASK_W-1:0] write_width;
    logic [XLEN-1:0]    dmem_write_data;
    logic [XLEN-1:0]    alu_result;
    logic [RD_W-1:0]    rd;
    logic               rd_we;
    logic [XLEN-1:0]    pc;
  } payload_t;

  logic [1:0] state_q;
  logic [1:0] state_d;
  payload_t   out_q;
  payload_t   skid_q;
  payload_t   in_payload;

  logic in_fire;
  logic out_fire;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid;

  // Bundle the EX fields so both registers load from one source.
  assign in_payload = '{
    is_write_dmem:   ex_is_write_dmem,
    wb_select:       ex_wb_select,
    write_width:     ex_write_width,
    dmem_write_data: ex_dmem_write_data,
    alu_result:      ex_alu_result,
    rd:              ex_rd,
    rd_we:           ex_rd_we,
    pc:              ex_pc
  };

  // Handshake flags; both depend only on flops plus the peer's own signal.
  assign ex_ready  = (state_q != ST_FULL);
  assign mem_valid = (state_q != ST_EMPTY);
  assign in_fire   = ex_valid & ex_ready;
  assign out_fire  = mem_valid & mem_ready;

  // Datapath load enables. A flush suppresses every load since the entries
  // are being discarded anyway.
  assign load_out_from_in   = ~flush & in_fire &
                              ((state_q == ST_EMPTY) ||
                               ((state_q == ST_ONE) && out_fire));
  assign load_skid          = ~flush & in_fire & (state_q == ST_ONE) & ~out_fire;
  assign load_out_from_skid = ~flush & (state_q == ST_FULL) & out_fire;

  // Next-state: flush beats every handshake event, then occupancy transitions.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned;
    // otherwise synthesis infers a latch.
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register; reset takes priority over flush.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (sys_rst) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  // OUT payload register: loads from EX or drains from SKID, else holds.
  always_ff @(posedge sys_clk) begin
    // NOTE: the payload registers are individual flops, not a RAM, and the
    // held mem_* fields must read 0 after reset, so they are reset here.
    if (sys_rst)                 out_q <= '0;
    else if (load_out_from_skid) out_q <= skid_q;
    else if (load_out_from_in)   out_q <= in_payload;
  end

  // SKID payload register: catches the entry accepted while OUT is stalled.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)        skid_q <= '0;
    else if (load_skid) skid_q <= in_payload;
  end

  // Outputs: side-effecting enables are gated so a bubble writes nothing.
  assign mem_is_write_dmem   = out_q.is_write_dmem & mem_valid;
  assign mem_rd_we           = out_q.rd_we & mem_valid;
  assign mem_wb_select       = out_q.wb_select;
  assign mem_write_width     = out_q.write_width;
  assign mem_dmem_write_data = out_q.dmem_write_data;
  assign mem_alu_result      = out_q.alu_result;
  assign mem_rd              = out_q.rd;
  assign mem_pc              = out_q.pc;

`ifdef EX_MEM_FWD_EN
  // ALU-result bypass: only a live, register-writing, ALU-sourced, non-x0
  // entry may forward.
  assign fwd_mem_valid = mem_valid & out_q.rd_we & (out_q.rd != '0) &
                         (out_q.wb_select == WBSEL_ALU);
  assign fwd_mem_rd    = out_q.rd;
  assign fwd_mem_data  = out_q.alu_result;
`endif

endmodule
